spi_master_arb: RTL and testbench

SPI_MASTER_ARB -- requirements
Module: spi_master_arb

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_rr_arbiter.sv | 27 ++
 rtl/spi_master_arb.sv | 187 ++++++++++++++++++
 tb/tb_spi_master_arb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the arbitrated SPI master: default geometry,
// one-hot state encoding and the round-robin pick function.
package spi_pkg;
  localparam int DATA_W_DEF  = 16;
  localparam int CLK_DIV_DEF = 4;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SETUP = 4'b0010,
    ST_XFER  = 4'b0100,
    ST_HOLD  = 4'b1000
  } state_t;

  // A tie goes to whichever requester was not served last.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last1);
    logic [1:0] pick;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last1 ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction
endpackage

// File: rtl/spi_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer advances only when a grant is taken.
module spi_rr_arbiter
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last1_r;

  // Remember which requester was served most recently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last1_r <= 1'b1;
    end else if (update) begin
      last1_r <= gnt[1];
    end else begin
      last1_r <= last1_r;
    end
  end

  assign gnt = rr_pick(req, last1_r);

endmodule

// File: rtl/spi_master_arb.sv
// SPI master shared by two requesters: arbitrates, latches mode and data at
// grant, then runs one LSB-first transfer with registered SPI outputs.
module spi_master_arb
  import spi_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CKP,
  input  logic              CPH,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] tx_data0,
  input  logic [DATA_W-1:0] tx_data1,
  output logic [1:0]        gnt,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              SCK,
  output logic              SS,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam int BIDX_W = EDGE_W - 1;

  state_t              state_r, state_s;
  logic [DIV_W-1:0]    div_cnt_r, div_cnt_s;
  logic [EDGE_W-1:0]   edge_cnt_r, edge_cnt_s;
  logic                sck_r, sck_s, ss_r, ss_s, mosi_r, mosi_s, done_r, done_s;
  logic [1:0]          gnt_r, gnt_s, arb_gnt_s;
  logic [DATA_W-1:0]   rx_data_r, rx_data_s, rx_shift_r, rx_shift_s, tx_r, tx_s;
  logic                ckp_r, ckp_s, cph_r, cph_s, arb_update_s;
  logic                div_wrap_s, last_bit_s;
  logic [DATA_W-1:0]   tx_sel_s;

  spi_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (arb_update_s),
    .gnt    (arb_gnt_s)
  );

  assign div_wrap_s = (div_cnt_r == DIV_W'(CLK_DIV - 1));
  assign last_bit_s = (edge_cnt_r[EDGE_W-1:1] == BIDX_W'(DATA_W - 1));
  assign tx_sel_s   = arb_gnt_s[1] ? tx_data1 : tx_data0;

  // Next-state and next-output computation for the whole transfer.
  always_comb begin
    state_s      = state_r;
    div_cnt_s    = div_cnt_r;
    edge_cnt_s   = edge_cnt_r;
    sck_s        = sck_r;
    ss_s         = ss_r;
    mosi_s       = mosi_r;
    gnt_s        = gnt_r;
    done_s       = 1'b0;
    rx_data_s    = rx_data_r;
    rx_shift_s   = rx_shift_r;
    tx_s         = tx_r;
    ckp_s        = ckp_r;
    cph_s        = cph_r;
    arb_update_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sck_s      = CKP;
        ss_s       = 1'b1;
        gnt_s      = 2'b00;
        div_cnt_s  = '0;
        edge_cnt_s = '0;
        if (req != 2'b00) begin
          arb_update_s = 1'b1;
          state_s      = ST_SETUP;
          gnt_s        = arb_gnt_s;
          ss_s         = 1'b0;
          ckp_s        = CKP;
          cph_s        = CPH;
          tx_s         = tx_sel_s;
          mosi_s       = tx_sel_s[0];
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        sck_s = ckp_r;
        if (div_wrap_s) begin
          div_cnt_s = '0;
          state_s   = ST_XFER;
        end else begin
          div_cnt_s = div_cnt_r + DIV_W'(1);
        end
      end
      ST_XFER: begin
        if (div_wrap_s) begin
          div_cnt_s  = '0;
          sck_s      = ~sck_r;
          edge_cnt_s = edge_cnt_r + EDGE_W'(1);
          // Even edge counts are leading edges; the sampling edge is the
          // leading one when CPH=0 and the trailing one when CPH=1.
          if (edge_cnt_r[0] == cph_r) begin
            rx_shift_s = {MISO, rx_shift_r[DATA_W-1:1]};
          end else if (cph_r) begin
            mosi_s = tx_r[0];
            tx_s   = {1'b0, tx_r[DATA_W-1:1]};
          end else if (!last_bit_s) begin
            mosi_s = tx_r[1];
            tx_s   = {1'b0, tx_r[DATA_W-1:1]};
          end else begin
            mosi_s = mosi_r;
          end
          if (edge_cnt_r == EDGE_W'(2 * DATA_W - 1)) begin
            state_s    = ST_HOLD;
            edge_cnt_s = '0;
          end else begin
            state_s = ST_XFER;
          end
        end else begin
          div_cnt_s = div_cnt_r + DIV_W'(1);
        end
      end
      ST_HOLD: begin
        sck_s = ckp_r;
        if (div_wrap_s) begin
          div_cnt_s = '0;
          state_s   = ST_IDLE;
          ss_s      = 1'b1;
          done_s    = 1'b1;
          rx_data_s = rx_shift_r;
          gnt_s     = 2'b00;
        end else begin
          div_cnt_s = div_cnt_r + DIV_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        ss_s    = 1'b1;
        gnt_s   = 2'b00;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      div_cnt_r  <= '0;
      edge_cnt_r <= '0;
      sck_r      <= 1'b0;
      ss_r       <= 1'b1;
      mosi_r     <= 1'b0;
      gnt_r      <= 2'b00;
      done_r     <= 1'b0;
      rx_data_r  <= '0;
      rx_shift_r <= '0;
      tx_r       <= '0;
      ckp_r      <= 1'b0;
      cph_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      div_cnt_r  <= div_cnt_s;
      edge_cnt_r <= edge_cnt_s;
      sck_r      <= sck_s;
      ss_r       <= ss_s;
      mosi_r     <= mosi_s;
      gnt_r      <= gnt_s;
      done_r     <= done_s;
      rx_data_r  <= rx_data_s;
      rx_shift_r <= rx_shift_s;
      tx_r       <= tx_s;
      ckp_r      <= ckp_s;
      cph_r      <= cph_s;
    end
  end

  assign gnt     = gnt_r;
  assign done    = done_r;
  assign rx_data = rx_data_r;
  assign busy    = (state_r != ST_IDLE);
  assign SCK     = sck_r;
  assign SS      = ss_r;
  assign MOSI    = mosi_r;

endmodule

// File: tb/tb_spi_master_arb.sv
// Bench for spi_master_arb: behavioural SPI slave plus a scoreboard of
// expected grant / MOSI word / received word per transaction.
module tb_spi_master_arb;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        CKP = 1'b0, CPH = 1'b0, MISO = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] tx_data0 = 16'hA5C3, tx_data1 = 16'h1234;
  logic [1:0]  gnt;
  logic        done, busy, SCK, SS, MOSI;
  logic [15:0] rx_data;

  typedef struct {
    logic [1:0]  g;
    logic [15:0] tx;
    logic [15:0] rx;
  } exp_t;
  exp_t sb[$];

  int          n_cmp = 0, n_bad = 0;
  int          done_cnt = 0, edges = 0, ss_len = 0, idx = 0;
  logic [15:0] slv_word = 16'h0402, mosi_cap = 16'h0000;
  logic [1:0]  gnt_cap = 2'b00;
  logic        s_ckp = 1'b0, s_cph = 1'b0, prev_ss = 1'b1, prev_sck = 1'b0;

  spi_master_arb dut (
    .clk(clk), .reset(reset), .CKP(CKP), .CPH(CPH), .req(req),
    .tx_data0(tx_data0), .tx_data1(tx_data1), .gnt(gnt), .done(done),
    .rx_data(rx_data), .busy(busy), .SCK(SCK), .SS(SS), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave model and scoreboard, evaluated on the falling clk edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_ss && !SS) begin
        s_ckp = CKP; s_cph = CPH; idx = 0; edges = 0; ss_len = 1;
        mosi_cap = 16'h0000; gnt_cap = gnt;
        if (!s_cph) MISO = slv_word[0];
      end else if (!SS) begin
        ss_len++;
        if (SCK != prev_sck) begin
          edges++;
          if (SCK != s_ckp) begin
            if (!s_cph) mosi_cap[idx] = MOSI;
            else if (idx < 16) MISO = slv_word[idx];
          end else begin
            if (!s_cph) begin
              idx++;
              if (idx < 16) MISO = slv_word[idx];
            end else begin
              mosi_cap[idx] = MOSI;
              idx++;
            end
          end
        end
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check_eq("unexpected_done", done, 1'b0);
        end else begin
          e = sb.pop_front();
          check_eq("gnt", gnt_cap, e.g);
          check_eq("mosi_word", mosi_cap, e.tx);
          check_eq("rx_data", rx_data, e.rx);
          check_eq("ss_low_len", ss_len, 32'd136);
          check_eq("busy_at_done", busy, 1'b0);
          check_eq("gnt_clr_at_done", gnt, 2'b00);
        end
      end
      prev_ss = SS;
      prev_sck = SCK;
    end
  end

  task automatic wait_dones(input int n, input int budget);
    int k = 0;
    int c = 0;
    while (k < n && c < budget) begin
      @(posedge clk); #1;
      c++;
      if (done) k++;
    end
    check_eq("done_wait", k, n);
  endtask

  task automatic wait_edges(input int n, input int budget);
    int c = 0;
    while (edges < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq("edge_wait", edges >= n, 1'b1);
  endtask

  task automatic run_txn(input logic ckp, input logic cph, input logic [1:0] r,
                         input logic [15:0] t0, input logic [15:0] word,
                         input logic [1:0] exp_g, input logic [15:0] exp_tx);
    exp_t e;
    @(negedge clk);
    CKP = ckp; CPH = cph; tx_data0 = t0; slv_word = word;
    repeat (2) @(posedge clk);
    #1 check_eq("sck_idle", SCK, ckp);
    e.g = exp_g; e.tx = exp_tx; e.rx = word;
    sb.push_back(e);
    @(negedge clk);
    req = r;
    @(posedge clk); #1;
    check_eq("gnt_at_t1", gnt, exp_g);
    check_eq("ss_at_t1", SS, 1'b0);
    check_eq("busy_at_t1", busy, 1'b1);
    req = 2'b00;
    wait_dones(1, 400);
  endtask

  initial begin
    exp_t e;
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ss", SS, 1'b1);
    check_eq("rst_sck", SCK, 1'b0);
    check_eq("rst_mosi", MOSI, 1'b0);
    check_eq("rst_gnt", gnt, 2'b00);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rx", rx_data, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Round robin with both requesters held: 01, 10, 01.
    e.rx = 16'h0402;
    e.g = 2'b01; e.tx = 16'hA5C3; sb.push_back(e);
    e.g = 2'b10; e.tx = 16'h1234; sb.push_back(e);
    e.g = 2'b01; e.tx = 16'hA5C3; sb.push_back(e);
    @(negedge clk);
    req = 2'b11;
    wait_dones(3, 1500);
    req = 2'b00;
    repeat (5) @(posedge clk);

    run_txn(1'b0, 1'b0, 2'b01, 16'hA5C3, 16'h0402, 2'b01, 16'hA5C3);
    run_txn(1'b1, 1'b1, 2'b01, 16'hA5C3, 16'h0402, 2'b01, 16'hA5C3);
    run_txn(1'b0, 1'b1, 2'b01, 16'hFFFF, 16'h0000, 2'b01, 16'hFFFF);
    run_txn(1'b1, 1'b0, 2'b01, 16'hFFFF, 16'h0000, 2'b01, 16'hFFFF);

    // Reset in the middle of XFER.
    @(negedge clk);
    CKP = 1'b0; CPH = 1'b0; tx_data0 = 16'hA5C3; slv_word = 16'h0402;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req = 2'b01;
    @(posedge clk);
    @(negedge clk); #1;
    wait_edges(10, 200);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    check_eq("arst_ss", SS, 1'b1);
    check_eq("arst_sck", SCK, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_gnt", gnt, 2'b00);
    req = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("arst_rx", rx_data, 16'h0000);
    check_eq("arst_no_done", done_cnt, d0);
    run_txn(1'b0, 1'b0, 2'b10, 16'hA5C3, 16'h0402, 2'b10, 16'h1234);

    // CPH flipped, req dropped and tx data changed mid-transfer.
    @(negedge clk);
    CKP = 1'b0; CPH = 1'b0; tx_data0 = 16'hA5C3; slv_word = 16'h0402;
    repeat (2) @(posedge clk);
    e.g = 2'b01; e.tx = 16'hA5C3; e.rx = 16'h0402; sb.push_back(e);
    d0 = done_cnt;
    @(negedge clk);
    req = 2'b01;
    @(posedge clk);
    @(negedge clk); #1;
    wait_edges(6, 200);
    CPH = 1'b1; req = 2'b00; tx_data0 = 16'h0000;
    wait_dones(1, 400);
    repeat (20) @(posedge clk);
    #1;
    check_eq("single_done", done_cnt - d0, 32'd1);
    check_eq("idle_after", busy, 1'b0);
    check_eq("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
